axi_rd_arbiter_n: RTL and testbench
===================================

// Module: axi_rd_arbiter_n
// PURPOSE
//  N-master AXI3 read-channel arbiter; successor to the fixed two-master (I/D cache) arbitration
//  at the CPU top. Grants one master's AR request and owns the AR/R channel until its burst ends.
//  Routes R beats back to the owner. Sits between the caches (plus future uncached/DMA masters)
//  and the outer AXI read port; the write channel is handled separately.
// PARAMETERS
//  NUM_MST  2   number of read masters, 1..16 (must be <= 2**ID_W)
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  ID_W     4   outer arid/rid width
// PORTS
//  clk         in   1               clock
//  rst         in   1               synchronous reset, active-high
//  m_araddr    in   NUM_MST*ADDR_W  per-master read address, master i at [i*ADDR_W +: ADDR_W]
//  m_arlen     in   NUM_MST*8       per-master burst length - 1
//  m_arvalid   in   NUM_MST         per-master AR valid
//  m_arready   out  NUM_MST         per-master AR ready
//  m_rdata     out  DATA_W          R data, broadcast to all masters
//  m_rlast     out  1               R last, broadcast
//  m_rvalid    out  NUM_MST         per-master R valid (only the owner's bit can be set)
//  m_rready    in   NUM_MST         per-master R ready
//  arid/araddr/arlen  out  ID_W/ADDR_W/8  outer AR; arid = owner index
//  arsize/arburst/arlock/arcache/arprot  out  3/2/2/4/3  constants 3'b010/2'b01/0/0/0
//  arvalid     out  1               outer AR valid
//  arready     in   1               outer AR ready
//  rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  outer R channel
//  rready      out  1               outer R ready
//  rd_err      out  1               sticky: rresp!=OKAY or rid!=owner seen on an accepted beat
// BEHAVIOUR
//  - FSM IDLE -> ADDR -> DATA -> IDLE; one outstanding burst total.
//  - IDLE: if any m_arvalid, pick winner, register owner index and its araddr/arlen, go ADDR
//    next cycle (1-cycle grant latency). No request: stay IDLE.
//  - ADDR: arvalid=1 with registered fields; m_arready[owner]=arready; on arvalid&&arready go DATA.
//    Registered fields must not change while in ADDR.
//  - DATA: m_rvalid[owner]=rvalid, rready=m_rready[owner], rdata/rlast passed combinationally;
//    on rvalid&&rready&&rlast go IDLE. Beats with rlast=0 do not change state.
//  - Non-owners: m_arready=0, m_rvalid=0 in all states. IDLE: arvalid=0, rready=0.
//  - A master dropping m_arvalid after grant is illegal; the burst completes anyway.
//  - Simultaneous requests: resolved by winner rule below; losers wait in IDLE on next pass.
//  - Reset (any state, incl. mid-burst): state=IDLE, arvalid=0, rready=0, all m_arready/m_rvalid=0,
//    owner=0, rd_err=0, RR pointer=0. Outer beats arriving after reset are dropped (rready=0).
// CONFIGURATION
//  ARB_RR_EN defined: round-robin; search starts at (last_owner+1) mod NUM_MST, pointer updates
//    on each grant. Two masters requesting continuously alternate grants.
//  ARB_RR_EN undefined: fixed priority, lowest index wins (index 0 = D-cache); no pointer state.
// TESTING
//  1 single req: m_arvalid=01, addr 0x1FC0_0000 len 7 -> arvalid 1 cycle later, arid=0,
//    8 beats to master 0 only, IDLE after rlast.
//  2 contention, RR on: both request every cycle -> grants 0,1,0,1; without ARB_RR_EN 0,0,0.
//  3 backpressure: arready low 5 cycles, m_rready[1] toggling -> araddr stable, no beat lost
//    or duplicated, rready tracks m_rready[1].
//  4 error: rresp=2'b10 on beat 3 (or rid=1 while owner=0) -> rd_err=1 and held until rst.
//  5 reset mid-burst after beat 2 of 8 -> next cycle IDLE, all valids/readies 0, new req
//    granted normally.
//  6 NUM_MST=4 build: masters 3 and 1 request together from pointer 2 -> RR grants 3 then 1.

Source files
------------

// File: rtl/axi_rd_arbiter_n.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter_n
//
// N-master AXI3 read-channel arbiter. One master's AR request is granted and
// that master then owns the outer AR/R channel until the last beat of its
// burst has been accepted. Only one burst is outstanding at a time.
//
// Configuration macro:
//   ARB_RR_EN  defined   -> round-robin. The search starts at the master after
//                           the last owner, and the pointer moves on each grant.
//              undefined -> fixed priority, lowest index wins. No pointer state.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m_araddr/m_arlen         per-master AR address / length-1 (packed, master i
//                            in slice i)
//   m_arvalid/m_arready      per-master AR handshake
//   m_rdata/m_rlast          R data/last, broadcast to every master
//   m_rvalid/m_rready        per-master R handshake (only the owner's bit is live)
//   arid..arvalid, arready   outer AR channel (arid = owner index)
//   rid..rvalid, rready      outer R channel
//   rd_err                   sticky: error response or wrong rid on an accepted beat
// ---------------------------------------------------------------------------
module axi_rd_arbiter_n #(
  parameter int NUM_MST = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // master side
  input  logic [NUM_MST*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MST*8-1:0]      m_arlen,
  input  logic [NUM_MST-1:0]        m_arvalid,
  output logic [NUM_MST-1:0]        m_arready,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_rlast,
  output logic [NUM_MST-1:0]        m_rvalid,
  input  logic [NUM_MST-1:0]        m_rready,
  // outer AR channel
  output logic [ID_W-1:0]           arid,
  output logic [ADDR_W-1:0]         araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  // outer R channel
  input  logic [ID_W-1:0]           rid,
  input  logic [DATA_W-1:0]         rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  // status
  output logic                      rd_err
);

  localparam int OWN_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_e;

  state_e             state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         len_q, len_d;
  logic               rd_err_q, rd_err_d;

  logic               req_any;
  logic [OWN_W-1:0]   win_idx;
  logic               r_hs;

  assign req_any = |m_arvalid;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
`ifdef ARB_RR_EN
  logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;

  // Walk from farthest to nearest so the last hit is the requester closest
  // to the pointer (inclusive).
  always_comb begin
    int idx;
    win_idx = rr_ptr_q;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      if (m_arvalid[OWN_W'(idx)]) win_idx = OWN_W'(idx);
    end
  end

  always_comb begin
    int nxt;
    rr_ptr_d = rr_ptr_q;
    nxt      = int'(win_idx) + 1;
    if (nxt >= NUM_MST) nxt = 0;
    if (state_q == ST_IDLE && req_any) rr_ptr_d = OWN_W'(nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  // Lowest index wins: scan downwards so index 0 is written last.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (m_arvalid[i]) win_idx = OWN_W'(i);
    end
  end
`endif

  // -------------------------------------------------------------------------
  // FSM next-state and channel steering
  // -------------------------------------------------------------------------
  assign r_hs = rvalid && m_rready[owner_q];

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    len_d     = len_q;
    rd_err_d  = rd_err_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          owner_d = win_idx;
          addr_d  = m_araddr[win_idx*ADDR_W +: ADDR_W];
          len_d   = m_arlen[win_idx*8 +: 8];
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        // Fields come from registers, so they hold steady under backpressure
        // regardless of what the master does with its own inputs.
        arvalid            = 1'b1;
        m_arready[owner_q] = arready;
        if (arready) state_d = ST_DATA;
      end

      ST_DATA: begin
        rready            = m_rready[owner_q];
        m_rvalid[owner_q] = rvalid;
        if (r_hs) begin
          if (rresp != 2'b00 || rid != ID_W'(owner_q)) rd_err_d = 1'b1;
          if (rlast) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rd_err_q <= rd_err_d;
    end
  end

  // NOTE: address/length are not reset; they are only presented while in
  // ADDR, which is always entered through a load from IDLE.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign arid    = ID_W'(owner_q);
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign m_rdata = rdata;
  assign m_rlast = rlast;
  assign rd_err  = rd_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter_n
//
// Four-master bench for axi_rd_arbiter_n. A cycle-level engine plays the
// masters and the outer AXI slave. It records every AR handshake and every
// delivered R beat. Each scenario task pushes its expected AR requests and
// beats to queues, runs the engine, and compares the observed queues in order.
// Expected grant orders follow ARB_RR_EN, so the bench suits either build.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter_n;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  typedef struct packed {
    logic [3:0]  mst;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [3:0]  mst;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*AW-1:0]  m_araddr;
  logic [NM*8-1:0]   m_arlen;
  logic [NM-1:0]     m_arvalid;
  logic [NM-1:0]     m_arready;
  logic [DW-1:0]     m_rdata;
  logic              m_rlast;
  logic [NM-1:0]     m_rvalid;
  logic [NM-1:0]     m_rready;
  logic [IW-1:0]     arid;
  logic [AW-1:0]     araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [IW-1:0]     rid;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              rd_err;

  int checks   = 0;
  int failures = 0;

  // master request configuration
  int          pend_n   [NM];
  int          req_k    [NM];
  logic [31:0] base_addr[NM];
  logic [7:0]  len_cfg  [NM];

  // scoreboard
  ar_t   exp_ar[$];
  ar_t   obs_ar[$];
  beat_t exp_beat[$];
  beat_t obs_beat[$];

  // engine observations
  int first_arvalid;
  int ar_unstable;
  int rready_viol;
  int onehot_viol;

  axi_rd_arbiter_n #(
    .NUM_MST(NM),
    .ADDR_W (AW),
    .DATA_W (DW),
    .ID_W   (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_araddr (m_araddr),
    .m_arlen  (m_arlen),
    .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata  (m_rdata),
    .m_rlast  (m_rlast),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready),
    .arid     (arid),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .arlock   (arlock),
    .arcache  (arcache),
    .arprot   (arprot),
    .arvalid  (arvalid),
    .arready  (arready),
    .rid      (rid),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .rvalid   (rvalid),
    .rready   (rready),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic do_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NM; i++) begin
      pend_n[i]    = 0;
      req_k[i]     = 0;
      base_addr[i] = 32'h0;
      len_cfg[i]   = 8'h0;
    end
    ar_unstable = 0;
    rready_viol = 0;
    onehot_viol = 0;
  endtask

  task automatic set_req(input int mst, input int n, input logic [31:0] base, input logic [7:0] len);
    pend_n[mst]    = n;
    base_addr[mst] = base;
    len_cfg[mst]   = len;
  endtask

  // Expected AR plus the first nbeats beats the slave model will return.
  task automatic push_exp(input int mst, input logic [31:0] addr, input logic [7:0] len, input int nbeats);
    ar_t   a;
    beat_t b;
    a.mst  = 4'(mst);
    a.addr = addr;
    a.len  = len;
    exp_ar.push_back(a);
    for (int k = 0; k < nbeats; k++) begin
      b.mst  = 4'(mst);
      b.data = addr ^ {4'(mst), 28'h0} ^ 32'(k);
      b.last = (k == int'(len));
      exp_beat.push_back(b);
    end
  endtask

  // Let the last accepted beat land, then park all inputs.
  task automatic go_idle();
    @(posedge clk);
    #1;
    m_arvalid = '0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rresp     = 2'b00;
    arready   = 1'b0;
    @(negedge clk);
  endtask

  // Cycle engine: inputs are driven 1 time unit after posedge, outputs are
  // sampled on negedge (what is seen there is what the next posedge takes).
  task automatic run_traffic(input int ar_stall, input bit tog_rready, input int err_beat,
                             input bit bad_rid, input int stop_after);
    int          cyc;
    int          ar_wait;
    int          beat;
    int          total;
    bit          s_active;
    logic [3:0]  s_id;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    logic [31:0] prev_addr;
    bit          prev_stall;
    bit          done;
    bit          busy;
    ar_t         oa;
    beat_t       ob;
    cyc = 0; ar_wait = 0; beat = 0; total = 0; s_active = 1'b0;
    s_id = '0; s_addr = '0; s_len = '0; prev_addr = '0; prev_stall = 1'b0; done = 1'b0;
    first_arvalid = -1;
    while (!done) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NM; i++) begin
        m_arvalid[i]          = (pend_n[i] > 0);
        m_araddr[i*AW +: AW]  = base_addr[i] + 32'(req_k[i]) * 32'h100;
        m_arlen[i*8 +: 8]     = len_cfg[i];
      end
      arready  = arvalid && (ar_wait >= ar_stall);
      rvalid   = s_active;
      rid      = bad_rid ? 4'(s_id + 4'd1) : s_id;
      rdata    = s_addr ^ {s_id, 28'h0} ^ 32'(beat);
      rlast    = s_active && (beat == int'(s_len));
      rresp    = (s_active && beat == err_beat) ? 2'b10 : 2'b00;
      m_rready = tog_rready ? (cyc[0] ? '1 : '0) : '1;

      @(negedge clk);
      if (arvalid && first_arvalid < 0) first_arvalid = cyc;
      if (prev_stall && arvalid && araddr !== prev_addr) ar_unstable++;
      prev_stall = arvalid && !arready;
      prev_addr  = araddr;
      if ($countones(m_arready) > 1 || $countones(m_rvalid) > 1) onehot_viol++;
      if (m_rvalid != '0 && !rvalid) onehot_viol++;
      if (s_active && rready !== m_rready[s_id]) rready_viol++;

      for (int i = 0; i < NM; i++) begin
        if (m_rvalid[i] && m_rready[i]) begin
          ob.mst  = 4'(i);
          ob.data = m_rdata;
          ob.last = m_rlast;
          obs_beat.push_back(ob);
        end
        if (m_arvalid[i] && m_arready[i]) begin
          pend_n[i]--;
          req_k[i]++;
        end
      end

      if (rvalid && rready) begin
        total++;
        if (rlast) s_active = 1'b0;
        else       beat++;
      end

      if (arvalid && arready) begin
        oa.mst  = arid;
        oa.addr = araddr;
        oa.len  = arlen;
        obs_ar.push_back(oa);
        s_active = 1'b1;
        s_id     = arid;
        s_addr   = araddr;
        s_len    = arlen;
        beat     = 0;
        ar_wait  = 0;
      end else if (arvalid) begin
        ar_wait++;
      end

      busy = s_active || arvalid;
      for (int i = 0; i < NM; i++) if (pend_n[i] > 0) busy = 1'b1;
      cyc++;
      if (stop_after > 0 && total >= stop_after) done = 1'b1;
      else if (!busy) done = 1'b1;
      else if (cyc > 2000) begin
        checks++;
        failures++;
        $display("FAIL engine_timeout got=%0d cycles exp=<2000", cyc);
        done = 1'b1;
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_rready = '1;
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b0; rresp = 2'b10; rid = 4'd3; rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b exp=0", rready); end
    checks++; if (m_arready !== 4'b0000) begin failures++; $display("FAIL reset_m_arready got=%b exp=0000", m_arready); end
    checks++; if (m_rvalid !== 4'b0000) begin failures++; $display("FAIL reset_m_rvalid got=%b exp=0000", m_rvalid); end
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL reset_rd_err got=%b exp=0", rd_err); end
    checks++; if (arid !== 4'd0) begin failures++; $display("FAIL reset_arid got=%0d exp=0", arid); end
    checks++;
    if ({arsize, arburst, arlock, arcache, arprot} !== {3'b010, 2'b01, 2'b00, 4'b0000, 3'b000}) begin
      failures++;
      $display("FAIL ar_consts got=%b exp=%b", {arsize, arburst, arlock, arcache, arprot},
               {3'b010, 2'b01, 2'b00, 4'b0000, 3'b000});
    end
  endtask

  task automatic test_single();
    ar_t ea, oa;
    beat_t eb, ob;
    clear_cfg();
    set_req(0, 1, 32'h1FC0_0000, 8'd7);
    push_exp(0, 32'h1FC0_0000, 8'd7, 8);
    run_traffic(0, 1'b0, -1, 1'b0, 0);
    checks++; if (first_arvalid != 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", first_arvalid); end
    checks++; if (onehot_viol != 0) begin failures++; $display("FAIL single_onehot got=%0d exp=0", onehot_viol); end
    while (exp_ar.size() > 0) begin
      ea = exp_ar.pop_front();
      checks++;
      if (obs_ar.size() == 0) begin failures++; $display("FAIL single_ar missing exp=%h", ea); end
      else begin oa = obs_ar.pop_front(); if (oa !== ea) begin failures++; $display("FAIL single_ar got=%h exp=%h", oa, ea); end end
    end
    while (exp_beat.size() > 0) begin
      eb = exp_beat.pop_front();
      checks++;
      if (obs_beat.size() == 0) begin failures++; $display("FAIL single_beat missing exp=%h", eb); end
      else begin ob = obs_beat.pop_front(); if (ob !== eb) begin failures++; $display("FAIL single_beat got=%h exp=%h", ob, eb); end end
    end
    checks++; if (obs_ar.size() + obs_beat.size() != 0) begin failures++; $display("FAIL single_extra got=%0d exp=0", obs_ar.size() + obs_beat.size()); end
    go_idle();
    checks++; if ({arvalid, rready} !== 2'b00) begin failures++; $display("FAIL single_idle got=%b exp=00", {arvalid, rready}); end
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL single_rd_err got=%b exp=0", rd_err); end
    obs_ar.delete(); obs_beat.delete();
  endtask

  task automatic test_contention();
    ar_t ea, oa;
    beat_t eb, ob;
    do_reset(2);
    clear_cfg();
    set_req(0, 2, 32'h1000_0000, 8'd3);
    set_req(1, 2, 32'h1100_0000, 8'd1);
`ifdef ARB_RR_EN
    push_exp(0, 32'h1000_0000, 8'd3, 4);
    push_exp(1, 32'h1100_0000, 8'd1, 2);
    push_exp(0, 32'h1000_0100, 8'd3, 4);
    push_exp(1, 32'h1100_0100, 8'd1, 2);
`else
    push_exp(0, 32'h1000_0000, 8'd3, 4);
    push_exp(0, 32'h1000_0100, 8'd3, 4);
    push_exp(1, 32'h1100_0000, 8'd1, 2);
    push_exp(1, 32'h1100_0100, 8'd1, 2);
`endif
    run_traffic(0, 1'b0, -1, 1'b0, 0);
    while (exp_ar.size() > 0) begin
      ea = exp_ar.pop_front();
      checks++;
      if (obs_ar.size() == 0) begin failures++; $display("FAIL contend_ar missing exp=%h", ea); end
      else begin oa = obs_ar.pop_front(); if (oa !== ea) begin failures++; $display("FAIL contend_ar got=%h exp=%h", oa, ea); end end
    end
    while (exp_beat.size() > 0) begin
      eb = exp_beat.pop_front();
      checks++;
      if (obs_beat.size() == 0) begin failures++; $display("FAIL contend_beat missing exp=%h", eb); end
      else begin ob = obs_beat.pop_front(); if (ob !== eb) begin failures++; $display("FAIL contend_beat got=%h exp=%h", ob, eb); end end
    end
    checks++; if (obs_ar.size() + obs_beat.size() != 0) begin failures++; $display("FAIL contend_extra got=%0d exp=0", obs_ar.size() + obs_beat.size()); end
    checks++; if (onehot_viol != 0) begin failures++; $display("FAIL contend_onehot got=%0d exp=0", onehot_viol); end
    go_idle();
    obs_ar.delete(); obs_beat.delete();
  endtask

  task automatic test_backpressure();
    ar_t ea, oa;
    beat_t eb, ob;
    clear_cfg();
    set_req(1, 1, 32'h2200_0040, 8'd5);
    push_exp(1, 32'h2200_0040, 8'd5, 6);
    run_traffic(5, 1'b1, -1, 1'b0, 0);
    checks++; if (ar_unstable != 0) begin failures++; $display("FAIL bp_araddr_stable got=%0d exp=0", ar_unstable); end
    checks++; if (rready_viol != 0) begin failures++; $display("FAIL bp_rready_track got=%0d exp=0", rready_viol); end
    while (exp_ar.size() > 0) begin
      ea = exp_ar.pop_front();
      checks++;
      if (obs_ar.size() == 0) begin failures++; $display("FAIL bp_ar missing exp=%h", ea); end
      else begin oa = obs_ar.pop_front(); if (oa !== ea) begin failures++; $display("FAIL bp_ar got=%h exp=%h", oa, ea); end end
    end
    while (exp_beat.size() > 0) begin
      eb = exp_beat.pop_front();
      checks++;
      if (obs_beat.size() == 0) begin failures++; $display("FAIL bp_beat missing exp=%h", eb); end
      else begin ob = obs_beat.pop_front(); if (ob !== eb) begin failures++; $display("FAIL bp_beat got=%h exp=%h", ob, eb); end end
    end
    checks++; if (obs_ar.size() + obs_beat.size() != 0) begin failures++; $display("FAIL bp_extra got=%0d exp=0", obs_ar.size() + obs_beat.size()); end
    go_idle();
    obs_ar.delete(); obs_beat.delete();
  endtask

  task automatic test_error();
    do_reset(2);
    clear_cfg();
    set_req(0, 1, 32'h5000_0000, 8'd7);
    run_traffic(0, 1'b0, 3, 1'b0, 0);
    go_idle();
    checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL err_rresp got=%b exp=1", rd_err); end
    clear_cfg();
    set_req(0, 1, 32'h5000_1000, 8'd1);
    run_traffic(0, 1'b0, -1, 1'b0, 0);
    go_idle();
    checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", rd_err); end
    do_reset(1);
    @(negedge clk);
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", rd_err); end
    clear_cfg();
    set_req(0, 1, 32'h5000_2000, 8'd1);
    run_traffic(0, 1'b0, -1, 1'b1, 0);
    go_idle();
    checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL err_rid got=%b exp=1", rd_err); end
    obs_ar.delete(); obs_beat.delete();
  endtask

  task automatic test_reset_mid_burst();
    ar_t ea, oa;
    beat_t eb, ob;
    do_reset(2);
    clear_cfg();
    set_req(0, 1, 32'h3000_0000, 8'd7);
    push_exp(0, 32'h3000_0000, 8'd7, 2);
    run_traffic(0, 1'b0, -1, 1'b0, 2);
    do_reset(1);
    @(negedge clk);
    checks++;
    if ({arvalid, rready, m_arready, m_rvalid} !== 10'b0) begin
      failures++;
      $display("FAIL midrst_idle got=%b exp=0", {arvalid, rready, m_arready, m_rvalid});
    end
    checks++; if (arid !== 4'd0) begin failures++; $display("FAIL midrst_owner got=%0d exp=0", arid); end
    clear_cfg();
    set_req(2, 1, 32'h3300_0000, 8'd3);
    push_exp(2, 32'h3300_0000, 8'd3, 4);
    run_traffic(0, 1'b0, -1, 1'b0, 0);
    while (exp_ar.size() > 0) begin
      ea = exp_ar.pop_front();
      checks++;
      if (obs_ar.size() == 0) begin failures++; $display("FAIL midrst_ar missing exp=%h", ea); end
      else begin oa = obs_ar.pop_front(); if (oa !== ea) begin failures++; $display("FAIL midrst_ar got=%h exp=%h", oa, ea); end end
    end
    while (exp_beat.size() > 0) begin
      eb = exp_beat.pop_front();
      checks++;
      if (obs_beat.size() == 0) begin failures++; $display("FAIL midrst_beat missing exp=%h", eb); end
      else begin ob = obs_beat.pop_front(); if (ob !== eb) begin failures++; $display("FAIL midrst_beat got=%h exp=%h", ob, eb); end end
    end
    checks++; if (obs_ar.size() + obs_beat.size() != 0) begin failures++; $display("FAIL midrst_extra got=%0d exp=0", obs_ar.size() + obs_beat.size()); end
    go_idle();
    obs_ar.delete(); obs_beat.delete();
  endtask

  task automatic test_rr_four();
    ar_t ea, oa;
    beat_t eb, ob;
    do_reset(2);
    clear_cfg();
    // Granting master 1 moves the round-robin pointer to 2.
    set_req(1, 1, 32'h4100_0000, 8'd0);
    push_exp(1, 32'h4100_0000, 8'd0, 1);
    run_traffic(0, 1'b0, -1, 1'b0, 0);
    clear_cfg();
    set_req(1, 1, 32'h4180_0000, 8'd0);
    set_req(3, 1, 32'h4300_0000, 8'd0);
`ifdef ARB_RR_EN
    push_exp(3, 32'h4300_0000, 8'd0, 1);
    push_exp(1, 32'h4180_0000, 8'd0, 1);
`else
    push_exp(1, 32'h4180_0000, 8'd0, 1);
    push_exp(3, 32'h4300_0000, 8'd0, 1);
`endif
    run_traffic(0, 1'b0, -1, 1'b0, 0);
    while (exp_ar.size() > 0) begin
      ea = exp_ar.pop_front();
      checks++;
      if (obs_ar.size() == 0) begin failures++; $display("FAIL rr4_ar missing exp=%h", ea); end
      else begin oa = obs_ar.pop_front(); if (oa !== ea) begin failures++; $display("FAIL rr4_ar got=%h exp=%h", oa, ea); end end
    end
    while (exp_beat.size() > 0) begin
      eb = exp_beat.pop_front();
      checks++;
      if (obs_beat.size() == 0) begin failures++; $display("FAIL rr4_beat missing exp=%h", eb); end
      else begin ob = obs_beat.pop_front(); if (ob !== eb) begin failures++; $display("FAIL rr4_beat got=%h exp=%h", ob, eb); end end
    end
    checks++; if (obs_ar.size() + obs_beat.size() != 0) begin failures++; $display("FAIL rr4_extra got=%0d exp=0", obs_ar.size() + obs_beat.size()); end
    go_idle();
    obs_ar.delete(); obs_beat.delete();
  endtask

  initial begin
    clear_cfg();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_error();
    test_reset_mid_burst();
    test_rr_four();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
